mem_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing the single-port synchronous 32x8 memory between N_REQ requesters
//  (e.g. CPU fetch/execute, debug/DMA loader). Accepts one access at a time, drives memory read/write/addr/data,

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between N_REQ requesters.
// One access in flight at a time: IDLE -> WRITE -> IDLE, or IDLE -> READ -> RESP -> IDLE.
module mem_arbiter #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ-1:0]          req_we_i,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
   output logic [N_REQ-1:0]          gnt_o,
   output logic [N_REQ-1:0]          done_o,
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      busy_o,
   output logic                      mem_read_o,
   output logic                      mem_write_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic [DATA_W-1:0]         mem_wdata_o,
   input  logic [DATA_W-1:0]         mem_rdata_i
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_RESP
   } state_e;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [N_REQ-1:0]    done_q, done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   logic                win_found;
   logic [PTR_W-1:0]    win_idx;
   logic [PTR_W-1:0]    cand;

   // Search starts just after the last winner so every requester is reached within N_REQ grants.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand = PTR_W'((int'(ptr_q) + off) % N_REQ);
         if (!win_found && req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = '0;
      done_d  = '0;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               ptr_d          = win_idx;
               gnt_d[win_idx] = 1'b1;
               addr_d         = req_addr_i[win_idx*ADDR_W +: ADDR_W];
               wdata_d        = req_wdata_i[win_idx*DATA_W +: DATA_W];
               state_d        = req_we_i[win_idx] ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            done_d[ptr_q] = 1'b1;
            state_d       = ST_IDLE;
         end
         ST_READ: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            rdata_d       = mem_rdata_i;
            done_d[ptr_q] = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= PTR_RST;
         gnt_q   <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Strobes decode directly from the state, so read and write are mutually exclusive by construction.
   assign mem_write_o = (state_q == ST_WRITE);
   assign mem_read_o  = (state_q == ST_READ);
   assign busy_o      = (state_q != ST_IDLE);
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 32x8 synchronous memory, round-robin order model and a
// scoreboard of expected completions popped whenever the DUT pulses done.
module tb_mem_arbiter;

   localparam int N_REQ  = 2;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   typedef struct {
      int          id;
      bit          rd;
      logic [7:0]  data;
   } exp_t;

   logic                     clk;
   logic                     rst;
   logic [N_REQ-1:0]         req;
   logic [N_REQ-1:0]         req_we;
   logic [N_REQ*ADDR_W-1:0]  req_addr;
   logic [N_REQ*DATA_W-1:0]  req_wdata;
   logic [N_REQ-1:0]         gnt;
   logic [N_REQ-1:0]         done;
   logic [DATA_W-1:0]        rdata;
   logic                     busy;
   logic                     mem_read;
   logic                     mem_write;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_wdata;
   logic [DATA_W-1:0]        mem_rdata = '0;

   logic [7:0]  mem [32];
   logic        mem_init_done = 1'b0;
   logic [7:0]  ref_mem [32];

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          rr_last  = N_REQ - 1;
   int          cyc      = 0;
   logic [N_REQ-1:0] gnt_prev  = '0;
   logic [N_REQ-1:0] done_prev = '0;

   mem_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .gnt_o       (gnt),
      .done_o      (done),
      .rdata_o     (rdata),
      .busy_o      (busy),
      .mem_read_o  (mem_read),
      .mem_write_o (mem_write),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory has no reset; contents seeded once, then plain synchronous read/write.
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 13 + 7);
         mem_init_done <= 1'b1;
      end else begin
         if (mem_write) mem[mem_addr] <= mem_wdata;
         if (mem_read)  mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("rw_mutex", 32'(mem_read & mem_write), 0);
      check("gnt_onehot", 32'($onehot0(gnt)), 1);
      check("done_onehot", 32'($onehot0(done)), 1);
      check("gnt_pulse", 32'(gnt & gnt_prev), 0);
      check("done_pulse", 32'(done & done_prev), 0);
      gnt_prev  <= gnt;
      done_prev <= done;
      if (done != '0) begin
         if (exp_q.size() == 0) begin
            check("done_unexpected", 32'(done), 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("done_id", 32'(done), 32'(1 << e.id));
            if (e.rd) check("rdata", 32'(rdata), 32'(e.data));
         end
      end
   end

   task automatic set_req(input int id, input bit we, input logic [4:0] a, input logic [7:0] d);
      req[id]                      = 1'b1;
      req_we[id]                   = we;
      req_addr[id*ADDR_W +: ADDR_W]  = a;
      req_wdata[id*DATA_W +: DATA_W] = d;
   endtask

   task automatic push_access(input int id, input bit we, input logic [4:0] a, input logic [7:0] d);
      exp_t e;
      e.id = id;
      e.rd = !we;
      e.data = we ? 8'h00 : ref_mem[a];
      if (we) ref_mem[a] = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_gnt(output int id);
      id = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (gnt != '0) begin
            for (int i = 0; i < N_REQ; i++) if (gnt[i]) id = i;
            break;
         end
      end
      if (id < 0) check("gnt_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      @(negedge clk);
      check("drain", 32'(exp_q.size()), 0);
      check("idle_busy", 32'(busy), 0);
   endtask

   task automatic run_single(input int id, input bit we, input logic [4:0] a, input logic [7:0] d);
      int g;
      set_req(id, we, a, d);
      push_access(id, we, a, d);
      rr_last = id;
      wait_gnt(g);
      check("single_gnt", 32'(g), 32'(id));
      req = '0;
      wait_idle();
   endtask

   task automatic run_pair(input bit we0, input logic [4:0] a0, input logic [7:0] d0,
                           input bit we1, input logic [4:0] a1, input logic [7:0] d1);
      bit         we [2];
      logic [4:0] a  [2];
      logic [7:0] d  [2];
      int         first, second, g;
      we[0] = we0; a[0] = a0; d[0] = d0;
      we[1] = we1; a[1] = a1; d[1] = d1;
      set_req(0, we0, a0, d0);
      set_req(1, we1, a1, d1);
      first  = (rr_last + 1) % N_REQ;
      second = 1 - first;
      push_access(first, we[first], a[first], d[first]);
      push_access(second, we[second], a[second], d[second]);
      rr_last = second;
      wait_gnt(g);
      check("pair_first", 32'(g), 32'(first));
      if (g >= 0) req[g] = 1'b0; else req = '0;
      wait_gnt(g);
      check("pair_second", 32'(g), 32'(second));
      req = '0;
      wait_idle();
   endtask

   initial begin
      int         g;
      int         prev_cyc;
      logic [7:0] old31;

      for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 13 + 7);
      rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_done", 32'(done), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_mem_rw", 32'({mem_read, mem_write}), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      rst = 1'b0;

      // Test 1: single write, exact cycle timing.
      set_req(0, 1'b1, 5'd5, 8'hA5);
      push_access(0, 1'b1, 5'd5, 8'hA5);
      rr_last = 0;
      @(negedge clk);
      check("t1_gnt", 32'(gnt), 32'b01);
      check("t1_mem_write", 32'(mem_write), 1);
      check("t1_mem_read", 32'(mem_read), 0);
      check("t1_mem_addr", 32'(mem_addr), 5);
      check("t1_mem_wdata", 32'(mem_wdata), 32'hA5);
      check("t1_busy", 32'(busy), 1);
      req = '0;
      @(negedge clk);
      check("t1_done", 32'(done), 32'b01);
      check("t1_busy_end", 32'(busy), 0);
      check("t1_mem_write_end", 32'(mem_write), 0);

      // Test 2: read back, accepted straight from the done cycle.
      set_req(0, 1'b0, 5'd5, 8'h00);
      push_access(0, 1'b0, 5'd5, 8'h00);
      @(negedge clk);
      check("t2_gnt", 32'(gnt), 32'b01);
      check("t2_mem_read", 32'(mem_read), 1);
      check("t2_mem_addr", 32'(mem_addr), 5);
      check("t2_busy1", 32'(busy), 1);
      req = '0;
      @(negedge clk);
      check("t2_busy2", 32'(busy), 1);
      check("t2_mem_read2", 32'(mem_read), 0);
      check("t2_no_done", 32'(done), 0);
      @(negedge clk);
      check("t2_done", 32'(done), 32'b01);
      check("t2_rdata", 32'(rdata), 32'hA5);
      check("t2_busy3", 32'(busy), 0);

      // Test 3: fresh reset, both requesters hold reads; grants must alternate every 3 cycles.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rr_last = N_REQ - 1;
      set_req(0, 1'b0, 5'd1, 8'h00);
      set_req(1, 1'b0, 5'd2, 8'h00);
      for (int k = 0; k < 4; k++) push_access(k % 2, 1'b0, (k % 2 == 0) ? 5'd1 : 5'd2, 8'h00);
      rr_last = 1;
      prev_cyc = 0;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(g);
         check("t3_rr_gnt", 32'(g), 32'(k % 2));
         if (k > 0) check("t3_rr_gap", 32'(cyc - prev_cyc), 3);
         prev_cyc = cyc;
         if (k == 3) req = '0;
      end
      wait_idle();

      // Test 4a: pointer at 1, so the queued read wins and sees the old value.
      old31 = ref_mem[31];
      run_pair(1'b0, 5'd31, 8'h00, 1'b1, 5'd31, 8'h3C);
      check("t4_rdata_hold", 32'(rdata), 32'(old31));
      // Test 4b: move pointer to 0, so the write wins and the read returns it.
      run_single(0, 1'b0, 5'd0, 8'h00);
      run_pair(1'b0, 5'd30, 8'h00, 1'b1, 5'd30, 8'h5A);
      run_single(1, 1'b0, 5'd31, 8'h00);

      // Test 5: reset while in READ aborts the access with no done; pointer restarts at req0.
      set_req(1, 1'b0, 5'd7, 8'h00);
      wait_gnt(g);
      check("t5_gnt", 32'(g), 1);
      check("t5_mem_read", 32'(mem_read), 1);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      check("t5_busy", 32'(busy), 0);
      check("t5_mem_read_off", 32'(mem_read), 0);
      check("t5_done", 32'(done), 0);
      check("t5_gnt_off", 32'(gnt), 0);
      rst = 1'b0;
      rr_last = N_REQ - 1;
      repeat (3) @(negedge clk);
      run_pair(1'b0, 5'd3, 8'h00, 1'b0, 5'd4, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
